// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO (register array + registered output stage) feeding uart_tx.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow flag (ovf) and its clear (ovf_clr).
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready
`ifdef UART_TX_FIFO_OVF_EN
  ,
  input  logic            ovf_clr,
  output logic            ovf
`endif
);

  localparam int unsigned PW  = ADDR_W + 1;
  localparam int unsigned CAP = DEPTH + 1;

  typedef enum logic {
    OUT_EMPTY  = 1'b0,
    OUT_LOADED = 1'b1
  } out_state_t;

  out_state_t    state;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count_nxt;
  logic [7:0]    rd_byte;
  logic          mem_empty;
  logic          wr_ok;
  logic          hs;

  assign tx_valid  = (state == OUT_LOADED);
  assign mem_empty = (wr_ptr == rd_ptr);
  assign wr_ok     = wr_en & ~full;
  assign hs        = tx_valid & tx_ready;
  assign rd_byte   = mem[rd_ptr[ADDR_W-1:0]];
  // Occupancy counts the output register too, so a load alone leaves it unchanged.
  assign count_nxt = count + PW'(wr_ok) - PW'(hs);

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Pointers, occupancy flags and output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= OUT_EMPTY;
      tx_data <= 8'h00;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == PW'(CAP));
      empty <= (count_nxt == '0);
      case (state)
        OUT_EMPTY: begin
          if (!mem_empty) begin
            tx_data <= rd_byte;
            rd_ptr  <= rd_ptr + PW'(1);
            state   <= OUT_LOADED;
          end
        end
        OUT_LOADED: begin
          if (tx_ready) begin
            if (!mem_empty) begin
              tx_data <= rd_byte;
              rd_ptr  <= rd_ptr + PW'(1);
            end else begin
              state <= OUT_EMPTY;
            end
          end
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Sticky drop indicator; a new drop beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ovf_clr;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf_clr  (ovf_clr),
    .ovf      (ovf)
`endif
  );

`ifndef UART_TX_FIFO_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every byte held by the block, front first.
  logic [7:0] q[$];
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_ovf;

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ovf   = 1'b0;
  endtask

  // A byte becomes visible one edge after it is written; the head is shown
  // whenever anything older than this edge's write remains after a handshake.
  task automatic model_edge(input bit we, input logic [7:0] wd, input bit rdy, input bit oclr);
    int n;
    bit hs;
    n  = q.size();
    hs = m_valid && rdy;
    if (we && n == 9) m_ovf = 1'b1;
    else if (oclr)    m_ovf = 1'b0;
    if (hs) void'(q.pop_front());
    m_valid = (n - int'(hs)) > 0;
    if (m_valid) m_data = q[0];
    if (we && n < 9) q.push_back(wd);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_edge(wr_en, wr_data, tx_ready, ovf_clr);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_valid"}, 32'(tx_valid), 32'(m_valid));
    chk({tag, "_data"},  32'(tx_data),  32'(m_data));
    chk({tag, "_count"}, 32'(count),    32'(q.size()));
    chk({tag, "_full"},  32'(full),     32'(q.size() == 9));
    chk({tag, "_empty"}, 32'(empty),    32'(q.size() == 0));
`ifdef UART_TX_FIFO_OVF_EN
    chk({tag, "_ovf"},   32'(ovf),      32'(m_ovf));
`endif
  endtask

  typedef struct {
    bit         we;
    logic [7:0] wd;
    bit         rdy;
    bit         ev;
    logic [7:0] ed;
    int         ec;
    bit         ef;
    bit         ee;
    bit         eo;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit we, logic [7:0] wd, bit rdy, bit ev, logic [7:0] ed,
                              int ec, bit ef, bit ee, bit eo);
    vec_t v;
    v.we = we; v.wd = wd; v.rdy = rdy; v.ev = ev; v.ed = ed;
    v.ec = ec; v.ef = ef; v.ee = ee; v.eo = eo;
    vt.push_back(v);
  endfunction

  logic [7:0] got[$];
  int         max_cnt;
  bit         saw_full;

  initial begin
    // Single byte, hold, release.
    add(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) add(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 0, 1'b0, 1'b1, 1'b0);
    // Fill to capacity, then a dropped write.
    for (int i = 0; i < 9; i++)
      add(1'b1, 8'(i), 1'b0, i > 0, (i > 0) ? 8'h00 : 8'hA5, i + 1, i == 8, 1'b0, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 9, 1'b1, 1'b0, 1'b1);
    // Drain one per cycle; the dropped 8'hFF must never appear.
    for (int i = 0; i < 8; i++)
      add(1'b0, 8'h00, 1'b1, 1'b1, 8'(i + 1), 8 - i, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h08, 0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h08, 0, 1'b0, 1'b1, 1'b1);

    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data",  32'(tx_data),  32'h00);
    chk("rst_empty", 32'(empty),    32'd1);
    chk("rst_full",  32'(full),     32'd0);
    chk("rst_count", 32'(count),    32'd0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("rst_ovf",   32'(ovf),      32'd0);
`endif

    foreach (vt[i]) begin
      wr_en = vt[i].we; wr_data = vt[i].wd; tx_ready = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_data", i),  32'(tx_data),  32'(vt[i].ed));
      chk($sformatf("vec%0d_count", i), 32'(count),    32'(vt[i].ec));
      chk($sformatf("vec%0d_full", i),  32'(full),     32'(vt[i].ef));
      chk($sformatf("vec%0d_empty", i), 32'(empty),    32'(vt[i].ee));
`ifdef UART_TX_FIFO_OVF_EN
      chk($sformatf("vec%0d_ovf", i),   32'(ovf),      32'(vt[i].eo));
`endif
    end
    wr_en = 1'b0; tx_ready = 1'b0;

`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clear", 32'(ovf), 32'd0);
`endif

    // Streaming through the pointer wrap with tx_ready held high.
    got.delete(); max_cnt = 0; saw_full = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      wr_en = (i < 20); wr_data = 8'(i);
      tick();
      if (tx_valid) got.push_back(tx_data);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (full) saw_full = 1'b1;
    end
    wr_en = 1'b0;
    chk("stream_len", 32'(got.size()), 32'd20);
    for (int i = 0; i < 20 && i < got.size(); i++)
      chk($sformatf("stream_byte%0d", i), 32'(got[i]), 32'(i));
    chk("stream_maxcount", 32'(max_cnt), 32'd2);
    chk("stream_nofull", 32'(saw_full), 32'd0);

    // Simultaneous write and handshake at count 4.
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    chk("sim_pre_count", 32'(count), 32'd4);
    chk("sim_pre_data", 32'(tx_data), 32'h10);
    wr_en = 1'b1; wr_data = 8'h14; tx_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("sim_count", 32'(count), 32'd4);
    chk("sim_data", 32'(tx_data), 32'h11);
    for (int i = 2; i < 5; i++) begin
      tick();
      chk($sformatf("sim_order%0d", i), 32'(tx_data), 32'h10 + 32'(i));
      chk($sformatf("sim_cnt%0d", i), 32'(count), 32'(5 - i));
    end
    tick();
    chk("sim_done_valid", 32'(tx_valid), 32'd0);

    // Asynchronous reset between edges with data pending.
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    chk("mid_pre_count", 32'(count), 32'd5);
    chk("mid_pre_valid", 32'(tx_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_valid", 32'(tx_valid), 32'd0);
    chk("mid_data",  32'(tx_data),  32'h00);
    chk("mid_count", 32'(count),    32'd0);
    chk("mid_empty", 32'(empty),    32'd1);
    chk("mid_full",  32'(full),     32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    tick();
    chk("mid_first_valid", 32'(tx_valid), 32'd1);
    chk("mid_first_data",  32'(tx_data),  32'h3C);

    // Randomized traffic against the model, with varying drain rates.
    rst = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      int pr;
      case (ph)
        0:       pr = 10;
        1:       pr = 50;
        2:       pr = 90;
        default: pr = 30;
      endcase
      for (int c = 0; c < 100; c++) begin
        wr_en    = ($urandom_range(99) < 60);
        wr_data  = 8'($urandom);
        tx_ready = (int'($urandom_range(99)) < pr);
        ovf_clr  = ($urandom_range(99) < 5);
        tick();
        chk_model($sformatf("rnd%0d_%0d", ph, c));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
